// File: rtl/wb_merge_pkg.sv
// Shared types for the writeback port merger.
// Defines the writeback entry payload and the fixed source index assignment.
package wb_merge_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned TID_W  = 3;

  localparam int unsigned SRC_FLU   = 0;
  localparam int unsigned SRC_LOAD  = 1;
  localparam int unsigned SRC_STORE = 2;
  localparam int unsigned SRC_FPU   = 3;

  typedef struct packed {
    logic [TID_W-1:0]  trans_id;
    logic [DATA_W-1:0] result;
    logic              ex_valid;
    logic [63:0]       ex_cause;
    logic [63:0]       ex_tval;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO for the writeback merger.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module wb_src_fifo
  import wb_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output wb_entry_t head,
  output logic      empty,
  output logic      full,
  output logic      afull
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] next_count;
  logic          do_push;
  logic          do_pop;
  wb_entry_t     mem [DEPTH];

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign next_count = count + PW'(do_push) - PW'(do_pop);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Pointer and almost-full register; flush empties the FIFO in one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      afull  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      afull <= (next_count >= PW'(DEPTH - 1));
    end
  end

  // Storage write; the payload array needs no reset since empty gates its use.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_port_merger.sv
// Merges NR_SRC non-stallable writeback streams onto NR_WB_PORTS scoreboard
// write ports with per-source FIFOs and round-robin arbitration.
// Optional feature macro: WB_MERGE_BYPASS_EN lets an empty-FIFO source be
// granted with its live input in the same cycle; without it every entry is
// buffered first and the ports only ever show FIFO heads.
module wb_port_merger
  import wb_merge_pkg::*;
#(
  parameter int unsigned NR_SRC      = 4,
  parameter int unsigned NR_WB_PORTS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic      [NR_SRC-1:0]       src_valid_i,
  input  wb_entry_t [NR_SRC-1:0]       src_entry_i,
  output logic      [NR_SRC-1:0]       src_afull_o,
  output logic      [NR_WB_PORTS-1:0]  wb_valid_o,
  output wb_entry_t [NR_WB_PORTS-1:0]  wb_entry_o,
  output logic                         overflow_o
);

  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic      [SRC_W-1:0]  rr_ptr;
  logic      [SRC_W-1:0]  rr_next;
  logic      [NR_SRC-1:0] fifo_empty;
  logic      [NR_SRC-1:0] fifo_full;
  logic      [NR_SRC-1:0] pending;
  logic      [NR_SRC-1:0] grant;
  logic      [NR_SRC-1:0] push;
  logic      [NR_SRC-1:0] pop;
  logic      [NR_SRC-1:0] drop;
  wb_entry_t [NR_SRC-1:0] fifo_head;
  wb_entry_t [NR_SRC-1:0] src_out;
  int unsigned            offset [NR_SRC];
  int unsigned            rank   [NR_SRC];

`ifdef WB_MERGE_BYPASS_EN
  assign pending = ~fifo_empty | src_valid_i;
  assign push    = src_valid_i & ~(grant & fifo_empty) & {NR_SRC{~flush_i}};

  // Empty FIFO hands the live input straight through; otherwise the head.
  always_comb begin
    src_out = '0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      src_out[i] = fifo_empty[i] ? src_entry_i[i] : fifo_head[i];
    end
  end
`else
  assign pending = ~fifo_empty;
  assign push    = src_valid_i & {NR_SRC{~flush_i}};
  assign src_out = fifo_head;
`endif

  assign pop  = grant & ~fifo_empty;
  assign drop = push & fifo_full & ~pop;

  for (genvar g = 0; g < NR_SRC; g++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush      (flush_i),
      .push       (push[g]),
      .pop        (pop[g]),
      .push_entry (src_entry_i[g]),
      .head       (fifo_head[g]),
      .empty      (fifo_empty[g]),
      .full       (fifo_full[g]),
      .afull      (src_afull_o[g])
    );
  end

  // Round-robin grant: rank each pending source by its distance from rr_ptr;
  // the first NR_WB_PORTS ranks win and rank k drives port k.
  always_comb begin
    int unsigned best_off;
    logic        found;
    grant      = '0;
    wb_valid_o = '0;
    wb_entry_o = '0;
    rr_next    = rr_ptr;
    best_off   = 0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      offset[i] = (i + NR_SRC - 32'(rr_ptr)) % NR_SRC;
    end
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      rank[i] = 0;
      for (int unsigned j = 0; j < NR_SRC; j++) begin
        if (pending[j] && (offset[j] < offset[i])) rank[i] = rank[i] + 1;
      end
      grant[i] = !flush_i && pending[i] && (rank[i] < NR_WB_PORTS);
    end
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      for (int unsigned i = 0; i < NR_SRC; i++) begin
        if (grant[i] && (rank[i] == k)) begin
          wb_valid_o[k] = 1'b1;
          wb_entry_o[k] = src_out[i];
        end
      end
    end
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      if (grant[i] && (!found || (offset[i] > best_off))) begin
        found    = 1'b1;
        best_off = offset[i];
        rr_next  = SRC_W'((i + 1) % NR_SRC);
      end
    end
  end

  // Round-robin pointer and sticky overflow flag; flush leaves overflow alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      rr_ptr <= flush_i ? '0 : rr_next;
      if (|drop) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_merger.sv
// Directed testbench for wb_port_merger (default build, no bypass).
// Instance dut uses two write ports; dut_p1 uses a single port for the
// fill/overflow scenario. Inputs change 1 time unit after a rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_wb_port_merger;
  import wb_merge_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;

  logic            flush_a;
  logic      [3:0] valid_a;
  wb_entry_t [3:0] entry_a;
  logic      [3:0] afull_a;
  logic      [1:0] wb_valid_a;
  wb_entry_t [1:0] wb_entry_a;
  logic            overflow_a;

  logic            flush_b;
  logic      [3:0] valid_b;
  wb_entry_t [3:0] entry_b;
  logic      [3:0] afull_b;
  logic      [0:0] wb_valid_b;
  wb_entry_t [0:0] wb_entry_b;
  logic            overflow_b;

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;

  always #5 clk_i = ~clk_i;

  wb_port_merger #(
    .NR_SRC(4), .NR_WB_PORTS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_a),
    .src_valid_i (valid_a),
    .src_entry_i (entry_a),
    .src_afull_o (afull_a),
    .wb_valid_o  (wb_valid_a),
    .wb_entry_o  (wb_entry_a),
    .overflow_o  (overflow_a)
  );

  wb_port_merger #(
    .NR_SRC(4), .NR_WB_PORTS(1), .FIFO_DEPTH(4)
  ) dut_p1 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_b),
    .src_valid_i (valid_b),
    .src_entry_i (entry_b),
    .src_afull_o (afull_b),
    .wb_valid_o  (wb_valid_b),
    .wb_entry_o  (wb_entry_b),
    .overflow_o  (overflow_b)
  );

  function automatic wb_entry_t mkEntry(input logic [2:0] tid, input logic [63:0] res);
    wb_entry_t e;
    e.trans_id = tid;
    e.result   = res;
    e.ex_valid = tid[0];
    e.ex_cause = {61'd0, tid};
    e.ex_tval  = ~res;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus for the chosen instance; the other instance idles.
  // Source i gets trans_id tids[3i+:3] and result res_base+i.
  task automatic applyStimulus(input bit to_p1, input logic [3:0] mask, input logic [11:0] tids,
                               input logic [63:0] res_base, input logic flush);
    @(posedge clk_i);
    #1;
    valid_a = '0;
    valid_b = '0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (to_p1) entry_b[i] = mkEntry(tids[3*i +: 3], res_base + 64'(i));
      else       entry_a[i] = mkEntry(tids[3*i +: 3], res_base + 64'(i));
    end
    if (to_p1) begin
      valid_b = mask;
      flush_b = flush;
    end else begin
      valid_a = mask;
      flush_a = flush;
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'b0000, 12'd0, 64'd0, 1'b0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    valid_a = '0;
    valid_b = '0;
    entry_a = '0;
    entry_b = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;

    // Reset state
    checkOutput("reset_wb_valid", 64'(wb_valid_a), 64'd0);
    checkOutput("reset_overflow", 64'(overflow_a), 64'd0);
    checkOutput("reset_afull", 64'(afull_a), 64'd0);
    checkOutput("reset_entry_zero", 64'(wb_entry_a == '0), 64'd1);

    // Collision: all four sources in one cycle, rr_ptr = 0
    applyStimulus(1'b0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h100, 1'b0);
    checkOutput("coll_push_cycle_valid", 64'(wb_valid_a), 64'd0);
    idle();
    checkOutput("coll_n_valid", 64'(wb_valid_a), 64'h3);
    checkOutput("coll_n_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd0);
    checkOutput("coll_n_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd1);
    checkOutput("coll_n_p0_res", wb_entry_a[0].result, 64'h100);
    checkOutput("coll_n_p1_res", wb_entry_a[1].result, 64'h101);
    idle();
    checkOutput("coll_n1_valid", 64'(wb_valid_a), 64'h3);
    checkOutput("coll_n1_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd2);
    checkOutput("coll_n1_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd3);
    checkOutput("coll_n1_p1_tval", wb_entry_a[1].ex_tval, ~64'h103);
    checkOutput("coll_n1_p1_cause", wb_entry_a[1].ex_cause, 64'd3);

    // Second collision: rr_ptr must be back at 0, so sources 0,1 go first
    applyStimulus(1'b0, 4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, 64'h200, 1'b0);
    checkOutput("rr_push_cycle_valid", 64'(wb_valid_a), 64'd0);
    idle();
    checkOutput("rr_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd4);
    checkOutput("rr_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd5);
    idle();
    checkOutput("rr_n1_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd6);
    checkOutput("rr_n1_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd7);

    // Single load result, one cycle latency
    applyStimulus(1'b0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 64'hDEAC, 1'b0);
    checkOutput("single_push_cycle_valid", 64'(wb_valid_a), 64'd0);
    idle();
    checkOutput("single_valid", 64'(wb_valid_a), 64'h1);
    checkOutput("single_tid", 64'(wb_entry_a[0].trans_id), 64'd5);
    checkOutput("single_res", wb_entry_a[0].result, 64'hDEAD);
    idle();
    checkOutput("single_after_valid", 64'(wb_valid_a), 64'd0);

    // Fairness: sources 0,1 every cycle, source 2 one pulse (rr_ptr = 2 here)
    applyStimulus(1'b0, 4'b0011, {3'd0, 3'd6, 3'd2, 3'd1}, 64'h220, 1'b0);
    checkOutput("fair_f0_valid", 64'(wb_valid_a), 64'd0);
    applyStimulus(1'b0, 4'b0011, {3'd0, 3'd6, 3'd2, 3'd1}, 64'h220, 1'b0);
    checkOutput("fair_f1_valid", 64'(wb_valid_a), 64'h3);
    checkOutput("fair_f1_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd1);
    applyStimulus(1'b0, 4'b0111, {3'd0, 3'd6, 3'd2, 3'd1}, 64'h220, 1'b0);
    checkOutput("fair_f2_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd2);
    applyStimulus(1'b0, 4'b0011, {3'd0, 3'd6, 3'd2, 3'd1}, 64'h220, 1'b0);
    checkOutput("fair_f3_valid", 64'(wb_valid_a), 64'h3);
    checkOutput("fair_src2_tid", 64'(wb_entry_a[0].trans_id), 64'd6);
    checkOutput("fair_src2_res", wb_entry_a[0].result, 64'h222);
    checkOutput("fair_f3_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd1);
    idle();
    checkOutput("fair_f4_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd2);
    checkOutput("fair_f4_p1_tid", 64'(wb_entry_a[1].trans_id), 64'd1);
    idle();
    checkOutput("fair_f5_valid", 64'(wb_valid_a), 64'h1);
    checkOutput("fair_f5_p0_tid", 64'(wb_entry_a[0].trans_id), 64'd2);
    idle();
    checkOutput("fair_drained", 64'(wb_valid_a), 64'd0);

    // Flush with three entries buffered
    applyStimulus(1'b0, 4'b0111, {3'd0, 3'd3, 3'd2, 3'd1}, 64'h300, 1'b0);
    checkOutput("flush_fill_valid", 64'(wb_valid_a), 64'd0);
    applyStimulus(1'b0, 4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, 64'h310, 1'b1);
    checkOutput("flush_cycle_valid", 64'(wb_valid_a), 64'd0);
    applyStimulus(1'b0, 4'b0100, {3'd0, 3'd4, 3'd0, 3'd0}, 64'h440, 1'b0);
    checkOutput("flush_after_valid", 64'(wb_valid_a), 64'd0);
    idle();
    checkOutput("flush_new_valid", 64'(wb_valid_a), 64'h1);
    checkOutput("flush_new_tid", 64'(wb_entry_a[0].trans_id), 64'd4);
    checkOutput("flush_new_res", wb_entry_a[0].result, 64'h442);
    idle();
    checkOutput("flush_end_valid", 64'(wb_valid_a), 64'd0);
    checkOutput("main_overflow", 64'(overflow_a), 64'd0);
    checkOutput("main_afull", 64'(afull_a), 64'd0);

    // Fill on the single-port instance: source 3 pushes 0x30.. every cycle
    applyStimulus(1'b1, 4'b0111, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h500, 1'b0);
    checkOutput("fill_p_valid", 64'(wb_valid_b), 64'd0);
    applyStimulus(1'b1, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h2D, 1'b0);
    checkOutput("fill_q_tid", 64'(wb_entry_b[0].trans_id), 64'd0);
    applyStimulus(1'b1, 4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h2E, 1'b0);
    checkOutput("fill_r_tid", 64'(wb_entry_b[0].trans_id), 64'd1);
    applyStimulus(1'b1, 4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h2F, 1'b0);
    checkOutput("fill_s_tid", 64'(wb_entry_b[0].trans_id), 64'd2);
    checkOutput("fill_afull_cnt2", 64'(afull_b), 64'd0);
    applyStimulus(1'b1, 4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h30, 1'b0);
    checkOutput("fill_afull_cnt3", 64'(afull_b), 64'h8);
    checkOutput("fill_t_res", wb_entry_b[0].result, 64'h30);
    applyStimulus(1'b1, 4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h31, 1'b0);
    checkOutput("fill_u_tid", 64'(wb_entry_b[0].trans_id), 64'd0);
    checkOutput("fill_u_overflow", 64'(overflow_b), 64'd0);
    applyStimulus(1'b1, 4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'h32, 1'b0);
    checkOutput("fill_v_tid", 64'(wb_entry_b[0].trans_id), 64'd1);
    checkOutput("fill_v_overflow", 64'(overflow_b), 64'd0);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("fill_drop_overflow", 64'(overflow_b), 64'd1);
    checkOutput("fill_w_tid", 64'(wb_entry_b[0].trans_id), 64'd2);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("drain_x_res", wb_entry_b[0].result, 64'h31);
    checkOutput("drain_x_afull", 64'(afull_b), 64'h8);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("drain_y_res", wb_entry_b[0].result, 64'h32);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("drain_z_res", wb_entry_b[0].result, 64'h33);
    checkOutput("drain_z_afull", 64'(afull_b), 64'd0);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("drain_aa_res", wb_entry_b[0].result, 64'h34);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("drain_empty_valid", 64'(wb_valid_b), 64'd0);
    checkOutput("overflow_sticky", 64'(overflow_b), 64'd1);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b1);
    checkOutput("p1_flush_valid", 64'(wb_valid_b), 64'd0);
    applyStimulus(1'b1, 4'b0000, 12'd0, 64'd0, 1'b0);
    checkOutput("overflow_kept_by_flush", 64'(overflow_b), 64'd1);
    checkOutput("load_index", 64'(SRC_LOAD + SRC_FPU), 64'(dut.g_fifo[SRC_FPU].u_fifo.DEPTH));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
